// File: rtl/conv28x28_seq_pkg.sv
// Shared constants and types for the conv28x28 sweep sequencer.
//   IMG_W / IMG_PIX : image geometry (28x28 output positions)
//   DP_W            : width of the datapath position index (dPstate)
//   state_t         : sequencer FSM encoding
//   core_w()        : kernel-index width, never narrower than one bit
package conv28x28_seq_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_PIX = IMG_W * IMG_W;
  localparam int DP_W    = 21;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // A single kernel still needs a one-bit select so ports never collapse
  // to zero width.
  function automatic int core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv28x28_seq_if.sv
// Result stream between the sequencer and its consumer.
//   pix_valid : result register holds an unconsumed result
//   pix_ready : consumer accepts when pix_valid && pix_ready
//   pix_data  : registered datapath result
//   pix_index : position (0..IMG_PIX-1) of pix_data
//   pix_core  : kernel index of pix_data
// master = sequencer side, slave = consumer side.
interface conv28x28_seq_if
  import conv28x28_seq_pkg::*;
#(
  parameter int IntSize = 8,
  parameter int CORE_W  = 3
) ();

  logic               pix_valid;
  logic               pix_ready;
  logic [IntSize-1:0] pix_data;
  logic [DP_W-1:0]    pix_index;
  logic [CORE_W-1:0]  pix_core;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_index,
    output pix_core,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_index,
    input  pix_core,
    output pix_ready
  );

endinterface

// File: rtl/conv28x28_seq.sv
// Sweep sequencer for the conv28x28 datapath. Walks every output position
// of every 5x5 kernel (kernel-major, position-ascending), presents the
// position/kernel to the external combinational datapath and registers its
// result into a one-deep valid/ready output slot.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a sweep (sampled only in IDLE)
//   busy      : high in RUN, DRAIN and DONE
//   done      : one-cycle pulse after the final result is accepted
//   dp_state  : position index to the datapath dPstate port
//   core_sel  : kernel index selecting the datapath core word
//   dp_out    : combinational datapath result for dp_state/core_sel
//   pix       : result stream (master side)
module conv28x28_seq
  import conv28x28_seq_pkg::*;
#(
  parameter int  NUM_CORES = 6,
  parameter int  IMG_PIX   = conv28x28_seq_pkg::IMG_PIX,
  parameter int  IntSize   = 8,
  localparam int CORE_W    = core_w(NUM_CORES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [DP_W-1:0]    dp_state,
  output logic [CORE_W-1:0]  core_sel,
  input  logic [IntSize-1:0] dp_out,
  conv28x28_seq_if.master    pix
);

  state_t state, state_nxt;

  logic slot_free;
  logic capture;
  logic last_pos;
  logic last_core;

  // The slot can take a new result when empty or being drained this cycle.
  assign slot_free = !pix.pix_valid || pix.pix_ready;
  assign capture   = (state == S_RUN) && slot_free;
  assign last_pos  = (dp_state == DP_W'(IMG_PIX - 1));
  assign last_core = (core_sel == CORE_W'(NUM_CORES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (capture && last_pos && last_core) state_nxt = S_DRAIN;
      S_DRAIN: if (pix.pix_valid && pix.pix_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Position/kernel counter: advances only on capture, so a stalled slot
  // freezes the datapath address. On the final capture the position wraps
  // while the kernel index holds; both return to zero through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_state <= '0;
      core_sel <= '0;
    end else if (capture) begin
      if (last_pos) begin
        dp_state <= '0;
        if (!last_core) core_sel <= core_sel + CORE_W'(1);
      end else begin
        dp_state <= dp_state + DP_W'(1);
      end
    end else if (state == S_DONE || state == S_IDLE) begin
      dp_state <= '0;
      core_sel <= '0;
    end
  end

  // Output slot: load on capture, otherwise empty it once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
      pix.pix_index <= '0;
      pix.pix_core  <= '0;
    end else if (capture) begin
      pix.pix_valid <= 1'b1;
      pix.pix_data  <= dp_out;
      pix.pix_index <= dp_state;
      pix.pix_core  <= core_sel;
    end else if (pix.pix_ready) begin
      pix.pix_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv28x28_seq.sv
// Bench for conv28x28_seq: one single-kernel and one two-kernel instance,
// each fed by a datapath stand-in returning (dp_state + core_sel) mod 256.
module tb_conv28x28_seq;
  import conv28x28_seq_pkg::*;

  localparam int NPIX = 784;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;

  always #5 clk = ~clk;

  logic            busy1, done1, busy2, done2;
  logic [DP_W-1:0] dp_state1, dp_state2;
  logic [0:0]      core_sel1, core_sel2;
  logic [7:0]      dp_out1, dp_out2;

  conv28x28_seq_if #(.IntSize(8), .CORE_W(1)) if1 ();
  conv28x28_seq_if #(.IntSize(8), .CORE_W(1)) if2 ();

  assign dp_out1 = 8'(dp_state1 + DP_W'(core_sel1));
  assign dp_out2 = 8'(dp_state2 + DP_W'(core_sel2));

  conv28x28_seq #(.NUM_CORES(1), .IMG_PIX(NPIX), .IntSize(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .dp_state(dp_state1), .core_sel(core_sel1), .dp_out(dp_out1), .pix(if1.master)
  );

  conv28x28_seq #(.NUM_CORES(2), .IMG_PIX(NPIX), .IntSize(8)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .dp_state(dp_state2), .core_sel(core_sel2), .dp_out(dp_out2), .pix(if2.master)
  );

  int n_chk = 0;
  int n_fail = 0;

  // scoreboard state: next expected (core, index), accepted count, done pulses
  int e1_idx = 0, e1_core = 0, cnt1 = 0, n_done1 = 0;
  int e2_idx = 0, e2_core = 0, cnt2 = 0, n_done2 = 0;

  typedef struct {
    int   k;
    logic valid;
    int   index;
    logic busy;
    logic done;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic a1, a2, r;
    int i1, c1, d1, i2, c2, d2;
    r  = rst;
    a1 = if1.pix_valid && if1.pix_ready;
    a2 = if2.pix_valid && if2.pix_ready;
    i1 = int'(if1.pix_index); c1 = int'(if1.pix_core); d1 = int'(if1.pix_data);
    i2 = int'(if2.pix_index); c2 = int'(if2.pix_core); d2 = int'(if2.pix_data);
    @(posedge clk); #1;
    if (a1 && !r) begin
      check("sb1_index", i1, e1_idx);
      check("sb1_core", c1, e1_core);
      check("sb1_data", d1, (e1_idx + e1_core) % 256);
      cnt1++;
      e1_idx++;
      if (e1_idx == NPIX) e1_idx = 0;
    end
    if (a2 && !r) begin
      check("sb2_index", i2, e2_idx);
      check("sb2_core", c2, e2_core);
      check("sb2_data", d2, (e2_idx + e2_core) % 256);
      cnt2++;
      e2_idx++;
      if (e2_idx == NPIX) begin
        e2_idx = 0;
        e2_core++;
      end
    end
    if (done1) begin
      n_done1++;
      check("done1_total", cnt1, NPIX);
    end
    if (done2) begin
      n_done2++;
      check("done2_total", cnt2, 2 * NPIX);
    end
  endtask

  task automatic reset_model1();
    e1_idx = 0; e1_core = 0; cnt1 = 0;
  endtask

  task automatic wait_idx1(input int idx, input string nm);
    int n;
    n = 0;
    while (!(if1.pix_valid && int'(if1.pix_index) == idx) && n < 2000) begin
      step();
      n++;
    end
    check(nm, int'(if1.pix_index), idx);
  endtask

  initial begin
    // expected timeline of the single-kernel sweep; k = edges after start
    tbl[0] = '{k: 0,   valid: 1'b0, index: 0,   busy: 1'b1, done: 1'b0};
    tbl[1] = '{k: 1,   valid: 1'b1, index: 0,   busy: 1'b1, done: 1'b0};
    tbl[2] = '{k: 2,   valid: 1'b1, index: 1,   busy: 1'b1, done: 1'b0};
    tbl[3] = '{k: 101, valid: 1'b1, index: 100, busy: 1'b1, done: 1'b0};
    tbl[4] = '{k: 300, valid: 1'b1, index: 299, busy: 1'b1, done: 1'b0};
    tbl[5] = '{k: 302, valid: 1'b1, index: 301, busy: 1'b1, done: 1'b0};
    tbl[6] = '{k: 784, valid: 1'b1, index: 783, busy: 1'b1, done: 1'b0};
    tbl[7] = '{k: 785, valid: 1'b0, index: 783, busy: 1'b1, done: 1'b1};
    tbl[8] = '{k: 786, valid: 1'b0, index: 783, busy: 1'b0, done: 1'b0};
    tbl[9] = '{k: 787, valid: 1'b0, index: 783, busy: 1'b0, done: 1'b0};

    if1.pix_ready = 1'b1;
    if2.pix_ready = 1'b1;

    // reset state
    step();
    step();
    rst = 1'b0;
    check("rst_busy1", int'(busy1), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_valid1", int'(if1.pix_valid), 0);
    check("rst_data1", int'(if1.pix_data), 0);
    check("rst_dp_state1", int'(dp_state1), 0);
    check("rst_busy2", int'(busy2), 0);
    check("rst_core_sel2", int'(core_sel2), 0);
    check("rst_index2", int'(if2.pix_index), 0);

    // single-kernel sweep, with start re-pulsed mid-sweep and in DONE
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k <= 787; k++) begin
      if (k > 0) step();
      for (int i = 0; i < 10; i++) begin
        if (tbl[i].k == k) begin
          check($sformatf("sweep1_valid_k%0d", k), int'(if1.pix_valid), int'(tbl[i].valid));
          check($sformatf("sweep1_busy_k%0d", k), int'(busy1), int'(tbl[i].busy));
          check($sformatf("sweep1_done_k%0d", k), int'(done1), int'(tbl[i].done));
          if (tbl[i].valid) begin
            check($sformatf("sweep1_index_k%0d", k), int'(if1.pix_index), tbl[i].index);
            check($sformatf("sweep1_data_k%0d", k), int'(if1.pix_data), tbl[i].index % 256);
          end
        end
      end
      start1 = (k == 299 || k == 785);
    end
    start1 = 1'b0;
    check("sweep1_single_done", n_done1, 1);
    check("idle_dp_state1", int'(dp_state1), 0);

    // new sweep from IDLE
    reset_model1();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("restart_valid", int'(if1.pix_valid), 1);
    check("restart_index", int'(if1.pix_index), 0);

    // backpressure: hold at index 100 for 5 cycles
    wait_idx1(100, "stall_reach_100");
    if1.pix_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      check("stall_index", int'(if1.pix_index), 100);
      check("stall_data", int'(if1.pix_data), 100);
      check("stall_valid", int'(if1.pix_valid), 1);
      check("stall_dp_state", int'(dp_state1), 101);
    end
    if1.pix_ready = 1'b1;
    step();
    check("release_index", int'(if1.pix_index), 101);

    // reset mid-sweep with a pending result
    wait_idx1(400, "rst_reach_400");
    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_model1();
    check("midrst_busy", int'(busy1), 0);
    check("midrst_done", int'(done1), 0);
    check("midrst_valid", int'(if1.pix_valid), 0);
    check("midrst_index", int'(if1.pix_index), 0);
    check("midrst_data", int'(if1.pix_data), 0);
    check("midrst_dp_state", int'(dp_state1), 0);
    check("midrst_no_done", n_done1, 1);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("postrst_valid", int'(if1.pix_valid), 1);
    check("postrst_index", int'(if1.pix_index), 0);

    // two-kernel sweep (u1 completes its restarted sweep meanwhile)
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int n = 0; n < 1700 && n_done2 == 0; n++) step();
    check("sweep2_done_seen", n_done2, 1);
    check("sweep2_total", cnt2, 2 * NPIX);
    check("sweep2_final_core", e2_core, 2);
    for (int n = 0; n < 5; n++) step();
    check("sweep2_single_done", n_done2, 1);
    check("sweep2_idle", int'(busy2), 0);
    check("sweep1_done_after_rst", n_done1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv28x28_seq.md
CONV28X28_SEQ -- requirements
Module: conv28x28_seq

Interface
REQ-001 Parameter NUM_CORES, default 6, number of 5x5 kernels swept per image.
REQ-002 Parameter IMG_PIX, default 784, output positions per kernel (28x28).
REQ-003 Parameter IntSize, default 8, pixel/result width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a full sweep; sampled only in IDLE.
REQ-007 busy  output  1  high in RUN, DRAIN and DONE.
REQ-008 done  output  1  one-cycle pulse when the final result has been accepted.
REQ-009 dp_state  output  21  position index driven to the conv28x28 datapath dPstate port.
REQ-010 core_sel  output  clog2(NUM_CORES)  kernel index selecting the core word fed to the datapath.
REQ-011 dp_out  input  IntSize  combinational datapath result for current dp_state/core_sel.
REQ-012 pix_valid  output  1  result register holds an unconsumed result.
REQ-013 pix_ready  input  1  downstream accepts result when pix_valid && pix_ready.
REQ-014 pix_data  output  IntSize  registered result.
REQ-015 pix_index  output  21  position (0..IMG_PIX-1) of pix_data.
REQ-016 pix_core  output  clog2(NUM_CORES)  kernel index of pix_data.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on capture of last position of last kernel; DRAIN->DONE when pix_valid && pix_ready; DONE->IDLE unconditionally after one cycle.
REQ-018 Slot free = !pix_valid || pix_ready; in RUN with slot free, capture: pix_data<=dp_out, pix_index<=dp_state, pix_core<=core_sel, pix_valid<=1.
REQ-019 On each capture dp_state increments; at IMG_PIX-1 it wraps to 0 and core_sel increments; at last kernel core_sel holds and FSM enters DRAIN.
REQ-020 In RUN with slot not free, dp_state, core_sel and result registers hold (no result lost or duplicated).
REQ-021 Latency: result for position p appears on pix_data one cycle after dp_state=p is presented with slot free.
REQ-022 Throughput: one result per cycle when pix_ready held high; total NUM_CORES*IMG_PIX results per sweep, in kernel-major, position-ascending order.
REQ-023 pix_valid clears on acceptance when no new capture occurs the same cycle (DRAIN, DONE, IDLE).
REQ-024 done asserted only in DONE; busy low only in IDLE.
REQ-025 start while busy is ignored; start in the DONE cycle is ignored; start accepted in IDLE the cycle after DONE.
REQ-026 In IDLE, dp_state=0 and core_sel=0.

Reset
REQ-027 rst forces IDLE, dp_state=0, core_sel=0, pix_valid=0, pix_data=0, pix_index=0, pix_core=0, done=0, busy=0, regardless of state.
REQ-028 rst mid-sweep abandons the sweep; no done pulse; pending result discarded.

Structure
REQ-029 Shared package holds IMG_W=28, IMG_PIX=784, FSM state enumeration and dp_state width constant (21).
REQ-030 No sub-module required; the position/kernel counter pair may be factored as sub-module conv_pos_counter.
REQ-031 Block instantiates nothing from the datapath; conv28x28 and core-word mux connect at the parent level.

Verification
REQ-032 NUM_CORES=1, pix_ready=1, start pulse -> 784 results, indices 0..783 consecutive cycles, done one cycle after index 783 accepted (cycle 786 after start).
REQ-033 NUM_CORES=2, pix_ready=1 -> pix_core 0 for indices 0..783 then pix_core 1 with index wrap 783->0, 1568 results total, single done.
REQ-034 pix_ready low for 5 cycles at index 100 -> pix_data/pix_index held at 100 for 5 cycles, dp_state frozen at 101, no gap or duplicate after release.
REQ-035 start re-pulsed at index 300 and during DONE -> ignored, sequence uninterrupted, exactly one done; start in following IDLE cycle begins new sweep at index 0.
REQ-036 rst asserted at index 400 with pix_valid=1 -> next cycle all outputs zero, IDLE, no done; subsequent start restarts at index 0.
REQ-037 Datapath model returning dp_out=(dp_state+core_sel) mod 256 -> every pix_data equals (pix_index+pix_core) mod 256.
